conv2d_mac_engine: RTL
======================

Name: conv2d_mac_engine

Overview:
- Parametrised sequential 2D-convolution engine for the super-resolution CNN datapath.
- Accepts one flattened IN_CH x K x K input window over a valid/ready handshake.
- For each output channel it multiply-accumulates against weights fetched from an external synchronous weight ROM, adds bias, rounds, shifts, applies optional ReLU and saturates.
- Emits OUT_CH results per window on a valid/ready output stream, tagged with the channel index.

Parameters:
- DATA_W, 8: input pixel/activation width.
- IN_SIGNED, 0: 0 = window elements unsigned, 1 = signed two's complement.
- WGT_W, 16: signed weight and bias width.
- ACC_W, 40: signed accumulator width; arithmetic wraps modulo 2^ACC_W.
- IN_CH, 3: input channels.
- OUT_CH, 8: output channels (kernels).
- K, 3: kernel height = width.
- SHIFT, 8: fixed-point right shift applied after bias; SHIFT = 0 means no shift and no rounding.
- OUT_W, 16: signed output width.
- RELU, 1: 1 = clamp negative results to 0.
- Derived: N = IN_CH*K*K; WA_W = clog2(OUT_CH*N); CH_W = max(1, clog2(OUT_CH)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- win_valid  in  1  window available.
- win_ready  out  1  engine can accept a window.
- win_data  in  N*DATA_W  tap t at [t*DATA_W +: DATA_W], with t = (c*K+ky)*K+kx.
- wgt_rd_en  out  1  weight ROM read strobe.
- wgt_addr  out  WA_W  = oc*N + t.
- wgt_data  in  WGT_W  signed weight, valid exactly 1 cycle after wgt_rd_en.
- bias_rd_en  out  1  bias ROM read strobe.
- bias_addr  out  CH_W  = oc.
- bias_data  in  WGT_W  signed bias, valid 1 cycle after bias_rd_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_W  signed result.
- out_ch  out  CH_W  output channel index of out_data.
- out_last  out  1  high with out_valid when out_ch = OUT_CH-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any time, including mid-window): state to IDLE; oc, tap and acc to 0; win_ready=1; all other outputs 0; the partially processed window is discarded.
- States: IDLE -> MAC -> DRAIN -> BIAS -> EMIT -> (MAC for next oc | IDLE).
- IDLE: win_ready=1. On win_valid&win_ready, register win_data internally, set oc=0 and acc=0, go to MAC. win_ready=0 in every other state.
- MAC: lasts N cycles. Cycle t drives wgt_rd_en=1 and wgt_addr=oc*N+t. Each cycle also adds the product of the previous cycle's tap: acc += ext(win[t-1]) * wgt_data. ext is zero-extension when IN_SIGNED=0 and sign-extension otherwise. After tap N-1 is issued, go to DRAIN.
- DRAIN: accumulate tap N-1; drive bias_rd_en=1, bias_addr=oc; go to BIAS.
- BIAS: compute r = (acc + sext(bias_data) + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift). If RELU and r<0, r=0. Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Register out_data, out_ch=oc, out_last=(oc==OUT_CH-1). Go to EMIT.
- EMIT: out_valid=1. out_data, out_ch and out_last are held stable until out_valid&out_ready.
  - On handshake, if oc<OUT_CH-1: oc++, acc=0, go to MAC in the same edge.
  - Otherwise go to IDLE, with out_valid low on the next cycle.
- Latency: out_valid rises N+2 edges after the accepting edge. Each subsequent channel takes N+3 cycles when out_ready is held high. One window takes OUT_CH*(N+3) cycles, plus 1 IDLE cycle before the next accept.
- wgt_rd_en and bias_rd_en are never asserted outside MAC and DRAIN respectively.
- Simultaneous events: win_valid during busy is ignored (win_ready=0) and the window must be held by the producer. out_ready while out_valid=0 has no effect.
- Accumulator overflow wraps silently. Saturation applies only to the final shifted value.

Test Plan:
- IN_CH=3, K=3, SHIFT=0, RELU=0: all pixels 1, all weights 1, bias 0 -> each of 8 outputs = 27; out_ch 0..7; out_last only on ch 7; first out_valid 29 edges after accept.
- Same config, weight at address oc*27+t = t-13 (signed), pixels = 2, bias = oc -> out_data = oc for each channel (sum of t-13 is 0). Verify the wgt_addr sequence 0..215 contiguous.
- SHIFT=8: acc+bias = 384 -> 2 (round half up); = -384 with RELU=0 -> -1; with RELU=1 -> 0.
- Saturation: pixels 255, weights 32767, bias 32767, SHIFT=0 -> out_data = 32767; weights -32768 with RELU=0 -> -32768.
- Backpressure: hold out_ready=0 for 10 cycles on ch 3 -> out_data/out_ch stable, no wgt_rd_en; release -> ch 4 MAC starts on the next cycle. win_valid asserted while busy -> not accepted.
- Assert rst mid-MAC on ch 5 -> outputs 0, win_ready=1 immediately; a new window afterwards produces correct ch 0..7 results.

Source files
------------

// File: rtl/conv2d_mac_engine.sv
// -----------------------------------------------------------------------------
// conv2d_mac_engine
//
// Sequential 2D-convolution engine for the super-resolution CNN datapath.
// One flattened IN_CH x K x K window is captured per handshake. Then, for every
// output channel in turn, the engine streams that channel's N weights out of an
// external synchronous ROM, multiply-accumulates them against the window,
// fetches and adds the channel bias, rounds, shifts, optionally applies ReLU and
// saturates. Each result goes out on a valid/ready stream, tagged with its
// channel index.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   win_valid / win_ready    input window handshake
//   win_data                 N*DATA_W flattened window, tap t at [t*DATA_W +: DATA_W]
//   wgt_rd_en / wgt_addr     weight ROM read strobe and address (oc*N + t)
//   wgt_data                 signed weight, valid one cycle after wgt_rd_en
//   bias_rd_en / bias_addr   bias ROM read strobe and address (oc)
//   bias_data                signed bias, valid one cycle after bias_rd_en
//   out_valid / out_ready    result handshake
//   out_data, out_ch         signed result and its output channel index
//   out_last                 marks the final channel of a window
//   busy                     engine is working on a window
// -----------------------------------------------------------------------------
module conv2d_mac_engine #(
    parameter int DATA_W    = 8,
    parameter int IN_SIGNED = 0,
    parameter int WGT_W     = 16,
    parameter int ACC_W     = 40,
    parameter int IN_CH     = 3,
    parameter int OUT_CH    = 8,
    parameter int K         = 3,
    parameter int SHIFT     = 8,
    parameter int OUT_W     = 16,
    parameter int RELU      = 1,
    localparam int N        = IN_CH * K * K,
    localparam int WA_W     = ($clog2(OUT_CH * N) > 0) ? $clog2(OUT_CH * N) : 1,
    localparam int CH_W     = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [N*DATA_W-1:0]     win_data,
    output logic                    wgt_rd_en,
    output logic [WA_W-1:0]         wgt_addr,
    input  logic signed [WGT_W-1:0] wgt_data,
    output logic                    bias_rd_en,
    output logic [CH_W-1:0]         bias_addr,
    input  logic signed [WGT_W-1:0] bias_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    busy
);

    localparam int TAP_W = (N > 1) ? $clog2(N) : 1;

    // Half an LSB of the shifted result; zero when there is no shift.
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'((64'sd1 <<< SHIFT) >>> 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        BIAS,
        EMIT
    } state_t;

    state_t                    state_q;
    logic [DATA_W-1:0]         win_q [N];
    logic [CH_W-1:0]           oc_q;
    logic [TAP_W-1:0]          tap_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic [WA_W-1:0]           wgtAddr_q;
    logic signed [OUT_W-1:0]   outData_q;
    logic signed [OUT_W-1:0]   outData_d;
    logic [CH_W-1:0]           outCh_q;
    logic                      outLast_q;

    logic [TAP_W-1:0]          tapSel;
    logic [DATA_W-1:0]         pix;
    logic signed [ACC_W-1:0]   pixExt;
    logic signed [ACC_W-1:0]   wgtExt;
    logic signed [ACC_W-1:0]   biasSum;
    logic signed [ACC_W-1:0]   shifted;

    // The weight arriving this cycle belongs to the tap issued one cycle ago,
    // so the pixel multiplied against it is the previous tap (or the last tap
    // while draining). The product wraps to ACC_W bits on purpose.
    always_comb begin
        tapSel = '0;
        if (state_q == DRAIN) begin
            tapSel = TAP_W'(N - 1);
        end else if (tap_q != '0) begin
            tapSel = tap_q - TAP_W'(1);
        end
        pix = win_q[tapSel];
        if (IN_SIGNED != 0) begin
            pixExt = ACC_W'(signed'(pix));
        end else begin
            pixExt = ACC_W'(pix);
        end
        wgtExt = ACC_W'(wgt_data);
        acc_d  = acc_q + pixExt * wgtExt;
    end

    // Post-processing of a finished accumulation: bias, round-half-up, arithmetic
    // shift, optional ReLU, then clamp into the signed output range.
    always_comb begin
        biasSum = acc_q + ACC_W'(bias_data) + ROUND;
        shifted = biasSum >>> SHIFT;
        if ((RELU != 0) && shifted[ACC_W-1]) begin
            shifted = '0;
        end
        if (shifted > OUT_MAX) begin
            outData_d = OUT_W'(OUT_MAX);
        end else if (shifted < OUT_MIN) begin
            outData_d = OUT_W'(OUT_MIN);
        end else begin
            outData_d = OUT_W'(shifted);
        end
    end

    // Main sequencer. wgt_addr runs contiguously through the ROM: it steps once
    // per issued tap and once more when moving to the next channel, which lands
    // exactly on oc*N for the new channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            oc_q      <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            wgtAddr_q <= '0;
            outData_q <= '0;
            outCh_q   <= '0;
            outLast_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        for (int i = 0; i < N; i++) begin
                            win_q[i] <= win_data[i*DATA_W +: DATA_W];
                        end
                        oc_q      <= '0;
                        tap_q     <= '0;
                        acc_q     <= '0;
                        wgtAddr_q <= '0;
                        state_q   <= MAC;
                    end
                end
                MAC: begin
                    if (tap_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (tap_q == TAP_W'(N - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        tap_q     <= tap_q + TAP_W'(1);
                        wgtAddr_q <= wgtAddr_q + WA_W'(1);
                    end
                end
                DRAIN: begin
                    acc_q   <= acc_d;
                    state_q <= BIAS;
                end
                BIAS: begin
                    outData_q <= outData_d;
                    outCh_q   <= oc_q;
                    outLast_q <= (oc_q == CH_W'(OUT_CH - 1));
                    state_q   <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (oc_q != CH_W'(OUT_CH - 1)) begin
                            oc_q      <= oc_q + CH_W'(1);
                            tap_q     <= '0;
                            acc_q     <= '0;
                            wgtAddr_q <= wgtAddr_q + WA_W'(1);
                            state_q   <= MAC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and strobe outputs decode straight from the state register.
    assign win_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign wgt_rd_en  = (state_q == MAC);
    assign bias_rd_en = (state_q == DRAIN);
    assign out_valid  = (state_q == EMIT);
    assign wgt_addr   = wgtAddr_q;
    assign bias_addr  = oc_q;
    assign out_data   = outData_q;
    assign out_ch     = outCh_q;
    assign out_last   = outLast_q;

endmodule
